// File: rtl/fwnoc_pkg.sv
// Shared fwnoc definitions: header flit layout, FSM state encodings and
// header pack/unpack helpers. Routers and endpoints both import this.
package fwnoc_pkg;

    localparam int FLIT_W  = 32;
    localparam int COORD_W = 4;
    localparam int LEN_W   = 8;
    localparam int TAG_W   = 8;

    // Bit offsets of each header field inside a header flit.
    localparam int HDR_DST_X_LSB = 0;
    localparam int HDR_DST_Y_LSB = 4;
    localparam int HDR_SRC_X_LSB = 8;
    localparam int HDR_SRC_Y_LSB = 12;
    localparam int HDR_LEN_LSB   = 16;
    localparam int HDR_TAG_LSB   = 24;

    // Packet FSM states; TX uses IDLE/HDR/PAY, RX additionally uses DROP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DROP = 2'd3
    } fwnoc_state_e;

    // Member order matches the flit layout: tag in [31:24] down to dst_x in [3:0].
    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [LEN_W-1:0]   len;
        logic [COORD_W-1:0] src_y;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] dst_y;
        logic [COORD_W-1:0] dst_x;
    } fwnoc_hdr_t;

    function automatic logic [FLIT_W-1:0] pack_hdr(input fwnoc_hdr_t h);
        logic [FLIT_W-1:0] f;
        f = '0;
        f[HDR_DST_X_LSB +: COORD_W] = h.dst_x;
        f[HDR_DST_Y_LSB +: COORD_W] = h.dst_y;
        f[HDR_SRC_X_LSB +: COORD_W] = h.src_x;
        f[HDR_SRC_Y_LSB +: COORD_W] = h.src_y;
        f[HDR_LEN_LSB   +: LEN_W]   = h.len;
        f[HDR_TAG_LSB   +: TAG_W]   = h.tag;
        return f;
    endfunction

    function automatic fwnoc_hdr_t unpack_hdr(input logic [FLIT_W-1:0] f);
        fwnoc_hdr_t h;
        h.dst_x = f[HDR_DST_X_LSB +: COORD_W];
        h.dst_y = f[HDR_DST_Y_LSB +: COORD_W];
        h.src_x = f[HDR_SRC_X_LSB +: COORD_W];
        h.src_y = f[HDR_SRC_Y_LSB +: COORD_W];
        h.len   = f[HDR_LEN_LSB   +: LEN_W];
        h.tag   = f[HDR_TAG_LSB   +: TAG_W];
        return h;
    endfunction

endpackage

// File: rtl/fwnoc_ep_rx.sv
// RX half of the endpoint: accepts packets from the router egress port,
// checks the destination, presents the header, then streams the payload.
// Misrouted packets raise a one-cycle rx_err and their payload is discarded.
//
// All streams use valid/ready: a beat transfers on a clock edge where both
// are high; once valid is raised it and its data hold until ready is seen.
module fwnoc_ep_rx
    import fwnoc_pkg::*;
#(
    parameter int unsigned X_ID = 0,
    parameter int unsigned Y_ID = 0
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               noc_i_valid,
    output logic               noc_i_ready,
    input  logic [FLIT_W-1:0]  noc_i_dat,

    output logic               rx_hdr_valid,
    input  logic               rx_hdr_ready,
    output logic [COORD_W-1:0] rx_src_x,
    output logic [COORD_W-1:0] rx_src_y,
    output logic [LEN_W-1:0]   rx_len,
    output logic [TAG_W-1:0]   rx_tag,

    output logic               rxd_valid,
    input  logic               rxd_ready,
    output logic [FLIT_W-1:0]  rxd_dat,
    output logic               rxd_last,

    output logic               rx_err,
    output logic [1:0]         dbg_state
);

    fwnoc_state_e       state, state_nxt;
    logic [LEN_W-1:0]   cnt;
    fwnoc_hdr_t         hdr_in;
    logic               dst_match;

    assign hdr_in    = unpack_hdr(noc_i_dat);
    assign dst_match = (hdr_in.dst_x == COORD_W'(X_ID)) && (hdr_in.dst_y == COORD_W'(Y_ID));
    assign rxd_dat   = noc_i_dat;
    assign dbg_state = state;

    // Next-state and handshake outputs; payload beats pass straight through.
    always_comb begin
        state_nxt    = state;
        noc_i_ready  = 1'b0;
        rx_hdr_valid = 1'b0;
        rxd_valid    = 1'b0;
        rxd_last     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                noc_i_ready = 1'b1;
                if (noc_i_valid) begin
                    if (dst_match)
                        state_nxt = ST_HDR;
                    else if (hdr_in.len != '0)
                        state_nxt = ST_DROP;
                end
            end
            ST_HDR: begin
                rx_hdr_valid = 1'b1;
                if (rx_hdr_ready)
                    state_nxt = (cnt != '0) ? ST_PAY : ST_IDLE;
            end
            ST_PAY: begin
                rxd_valid   = noc_i_valid;
                noc_i_ready = rxd_ready;
                rxd_last    = (cnt == LEN_W'(1));
                if (noc_i_valid && rxd_ready && cnt == LEN_W'(1))
                    state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                noc_i_ready = 1'b1;
                if (noc_i_valid && cnt == LEN_W'(1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, beat counter, captured header fields and the error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rx_src_x <= '0;
            rx_src_y <= '0;
            rx_len   <= '0;
            rx_tag   <= '0;
            rx_err   <= 1'b0;
        end else begin
            state  <= state_nxt;
            rx_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (noc_i_valid) begin
                        rx_src_x <= hdr_in.src_x;
                        rx_src_y <= hdr_in.src_y;
                        rx_len   <= hdr_in.len;
                        rx_tag   <= hdr_in.tag;
                        cnt      <= hdr_in.len;
                        rx_err   <= !dst_match;
                    end
                end
                ST_PAY: begin
                    // cnt is never zero here; the guard keeps it from wrapping.
                    if (noc_i_valid && rxd_ready && cnt != '0)
                        cnt <= cnt - LEN_W'(1);
                end
                ST_DROP: begin
                    if (noc_i_valid && cnt != '0)
                        cnt <= cnt - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fwnoc_ep.sv
// fwnoc network endpoint: host side of a router's home port. TX builds a
// header flit plus payload flits for the router ingress; RX (sub-module)
// unpacks packets from the router egress for the host.
//
// All streams use valid/ready: a beat transfers on a clock edge where both
// are high; once valid is raised it and its data hold until ready is seen.
module fwnoc_ep
    import fwnoc_pkg::*;
#(
    parameter int unsigned X_ID = 0,
    parameter int unsigned Y_ID = 0
) (
    input  logic               clock,
    input  logic               reset,

    output logic               noc_e_valid,
    input  logic               noc_e_ready,
    output logic [FLIT_W-1:0]  noc_e_dat,

    input  logic               noc_i_valid,
    output logic               noc_i_ready,
    input  logic [FLIT_W-1:0]  noc_i_dat,

    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [COORD_W-1:0] tx_dst_x,
    input  logic [COORD_W-1:0] tx_dst_y,
    input  logic [LEN_W-1:0]   tx_len,
    input  logic [TAG_W-1:0]   tx_tag,

    input  logic               txd_valid,
    output logic               txd_ready,
    input  logic [FLIT_W-1:0]  txd_dat,

    output logic               rx_hdr_valid,
    input  logic               rx_hdr_ready,
    output logic [COORD_W-1:0] rx_src_x,
    output logic [COORD_W-1:0] rx_src_y,
    output logic [LEN_W-1:0]   rx_len,
    output logic [TAG_W-1:0]   rx_tag,

    output logic               rxd_valid,
    input  logic               rxd_ready,
    output logic [FLIT_W-1:0]  rxd_dat,
    output logic               rxd_last,

    output logic               rx_err,

    output logic [1:0]         dbg_tx_state,
    output logic [1:0]         dbg_rx_state
);

    fwnoc_state_e      tx_state, tx_state_nxt;
    logic [LEN_W-1:0]  tx_cnt;
    logic [FLIT_W-1:0] tx_hdr;
    fwnoc_hdr_t        tx_hdr_new;

    assign dbg_tx_state = tx_state;

    // Header for the command on the TX port; source is always this endpoint.
    always_comb begin
        tx_hdr_new       = '0;
        tx_hdr_new.dst_x = tx_dst_x;
        tx_hdr_new.dst_y = tx_dst_y;
        tx_hdr_new.src_x = COORD_W'(X_ID);
        tx_hdr_new.src_y = COORD_W'(Y_ID);
        tx_hdr_new.len   = tx_len;
        tx_hdr_new.tag   = tx_tag;
    end

    // TX next-state and outputs; payload flits pass through with no latency.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_ready     = 1'b0;
        txd_ready    = 1'b0;
        noc_e_valid  = 1'b0;
        noc_e_dat    = tx_hdr;
        unique case (tx_state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid)
                    tx_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                noc_e_valid = 1'b1;
                if (noc_e_ready)
                    tx_state_nxt = (tx_cnt != '0) ? ST_PAY : ST_IDLE;
            end
            ST_PAY: begin
                noc_e_valid = txd_valid;
                noc_e_dat   = txd_dat;
                txd_ready   = noc_e_ready;
                if (txd_valid && noc_e_ready && tx_cnt == LEN_W'(1))
                    tx_state_nxt = ST_IDLE;
            end
            default: tx_state_nxt = ST_IDLE;
        endcase
    end

    // TX state, registered header and remaining-payload counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_hdr   <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_state == ST_IDLE && tx_valid) begin
                tx_hdr <= pack_hdr(tx_hdr_new);
                tx_cnt <= tx_len;
            end else if (tx_state == ST_PAY && txd_valid && noc_e_ready && tx_cnt != '0) begin
                tx_cnt <= tx_cnt - LEN_W'(1);
            end
        end
    end

    fwnoc_ep_rx #(
        .X_ID (X_ID),
        .Y_ID (Y_ID)
    ) u_rx (
        .clock        (clock),
        .reset        (reset),
        .noc_i_valid  (noc_i_valid),
        .noc_i_ready  (noc_i_ready),
        .noc_i_dat    (noc_i_dat),
        .rx_hdr_valid (rx_hdr_valid),
        .rx_hdr_ready (rx_hdr_ready),
        .rx_src_x     (rx_src_x),
        .rx_src_y     (rx_src_y),
        .rx_len       (rx_len),
        .rx_tag       (rx_tag),
        .rxd_valid    (rxd_valid),
        .rxd_ready    (rxd_ready),
        .rxd_dat      (rxd_dat),
        .rxd_last     (rxd_last),
        .rx_err       (rx_err),
        .dbg_state    (dbg_rx_state)
    );

endmodule

// File: tb/tb_fwnoc_ep.sv
// Bench for fwnoc_ep at X_ID=1, Y_ID=0: directed packets on TX and RX,
// scoreboard queues filled by the stimulus and drained by output monitors.
module tb_fwnoc_ep;
    import fwnoc_pkg::*;

    localparam int X_ID = 1;
    localparam int Y_ID = 0;

    logic        clock = 1'b0;
    logic        reset;
    logic        noc_e_valid, noc_e_ready;
    logic [31:0] noc_e_dat;
    logic        noc_i_valid, noc_i_ready;
    logic [31:0] noc_i_dat;
    logic        tx_valid, tx_ready;
    logic [3:0]  tx_dst_x, tx_dst_y;
    logic [7:0]  tx_len, tx_tag;
    logic        txd_valid, txd_ready;
    logic [31:0] txd_dat;
    logic        rx_hdr_valid, rx_hdr_ready;
    logic [3:0]  rx_src_x, rx_src_y;
    logic [7:0]  rx_len, rx_tag;
    logic        rxd_valid, rxd_ready;
    logic [31:0] rxd_dat;
    logic        rxd_last;
    logic        rx_err;
    logic [1:0]  dbg_tx_state, dbg_rx_state;

    // ---------------- clock / reset ----------------
    initial forever #5 clock = ~clock;

    fwnoc_ep #(.X_ID(X_ID), .Y_ID(Y_ID)) dut (
        .clock(clock), .reset(reset),
        .noc_e_valid(noc_e_valid), .noc_e_ready(noc_e_ready), .noc_e_dat(noc_e_dat),
        .noc_i_valid(noc_i_valid), .noc_i_ready(noc_i_ready), .noc_i_dat(noc_i_dat),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
        .tx_len(tx_len), .tx_tag(tx_tag),
        .txd_valid(txd_valid), .txd_ready(txd_ready), .txd_dat(txd_dat),
        .rx_hdr_valid(rx_hdr_valid), .rx_hdr_ready(rx_hdr_ready),
        .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_len(rx_len), .rx_tag(rx_tag),
        .rxd_valid(rxd_valid), .rxd_ready(rxd_ready), .rxd_dat(rxd_dat), .rxd_last(rxd_last),
        .rx_err(rx_err),
        .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_tx_q[$];   // flits expected on noc_e
    logic [23:0] exp_rxh_q[$];  // {tag, len, src_y, src_x} expected on rx_hdr
    logic [32:0] exp_rxd_q[$];  // {last, dat} expected on rxd
    int          exp_err  = 0;  // rx_err pulses still expected
    logic [31:0] tx_words[$];   // payload the TX driver sends next
    bit          rand_stall = 1'b0;
    bit          watch_txd  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_extra(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h, expected no transfer (t=%0t)", name, act, $time);
    endtask

    // Monitors sample at negedge; drivers only change inputs just after posedge.
    always @(negedge clock) begin
        if (noc_e_valid && noc_e_ready) begin
            if (exp_tx_q.size() == 0) flag_extra("noc_e_flit", 64'(noc_e_dat));
            else check("noc_e_flit", 64'(noc_e_dat), 64'(exp_tx_q.pop_front()));
        end
        if (rx_hdr_valid && rx_hdr_ready) begin
            if (exp_rxh_q.size() == 0) flag_extra("rx_hdr", 64'({rx_tag, rx_len, rx_src_y, rx_src_x}));
            else check("rx_hdr", 64'({rx_tag, rx_len, rx_src_y, rx_src_x}), 64'(exp_rxh_q.pop_front()));
        end
        if (rxd_valid && rxd_ready) begin
            if (exp_rxd_q.size() == 0) flag_extra("rxd_beat", 64'({rxd_last, rxd_dat}));
            else check("rxd_beat", 64'({rxd_last, rxd_dat}), 64'(exp_rxd_q.pop_front()));
        end
        if (rx_err) begin
            if (exp_err == 0) flag_extra("rx_err_pulse", 64'(rx_err));
            else begin
                check("rx_err_pulse", 64'(rx_err), 64'd1);
                exp_err--;
            end
        end
        if (watch_txd) check("txd_ready_zero_len", 64'(txd_ready), 64'd0);
    end

    // noc_e_ready: always high, or random stalls while rand_stall is set.
    initial begin
        noc_e_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            noc_e_ready = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tx_idle();
        int b = 0;
        while (dbg_tx_state != 2'(ST_IDLE) && b < 2000) begin step(); b++; end
        check("tx_back_to_idle", 64'(dbg_tx_state), 64'(ST_IDLE));
    endtask

    task automatic wait_rx_idle();
        int b = 0;
        while (dbg_rx_state != 2'(ST_IDLE) && b < 200) begin step(); b++; end
        check("rx_back_to_idle", 64'(dbg_rx_state), 64'(ST_IDLE));
    endtask

    // Issue one TX command; payload comes from tx_words.
    task automatic send_tx(input logic [3:0] dx, input logic [3:0] dy,
                           input logic [7:0] len, input logic [7:0] tag);
        int  b;
        bit  hs;
        tx_valid = 1'b1; tx_dst_x = dx; tx_dst_y = dy; tx_len = len; tx_tag = tag;
        b = 0;
        do begin @(negedge clock); hs = tx_ready; step(); b++; end while (!hs && b < 50);
        check("tx_cmd_accept", 64'(hs), 64'd1);
        tx_valid = 1'b0;
        check("tx_hdr_latency", 64'(noc_e_valid), 64'd1);
        for (int i = 0; i < int'(len); i++) begin
            if (rand_stall) begin
                txd_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            txd_valid = 1'b1;
            txd_dat   = tx_words.pop_front();
            b = 0;
            do begin @(negedge clock); hs = txd_ready; step(); b++; end while (!hs && b < 200);
            if (!hs) begin check("txd_accept", 64'(hs), 64'd1); break; end
        end
        txd_valid = 1'b0;
        wait_tx_idle();
    endtask

    // Offer one flit on the router egress side and wait for it to be taken.
    task automatic send_rx_flit(input logic [31:0] dat);
        int b = 0;
        bit hs;
        noc_i_valid = 1'b1;
        noc_i_dat   = dat;
        do begin @(negedge clock); hs = noc_i_ready; step(); b++; end while (!hs && b < 100);
        check("noc_i_accept", 64'(hs), 64'd1);
        noc_i_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        tx_valid = 0; tx_dst_x = 0; tx_dst_y = 0; tx_len = 0; tx_tag = 0;
        txd_valid = 0; txd_dat = 0;
        noc_i_valid = 0; noc_i_dat = 0;
        rx_hdr_ready = 1'b1; rxd_ready = 1'b1;
        repeat (3) step();
        // {noc_e_valid, txd_ready, tx_ready, noc_i_ready, hdr_v, rxd_v, last, err, fields, states}
        check("reset_values", 64'({noc_e_valid, txd_ready, tx_ready, noc_i_ready, rx_hdr_valid,
              rxd_valid, rxd_last, rx_err, rx_src_x, rx_src_y, rx_len, rx_tag,
              dbg_tx_state, dbg_rx_state}), 64'({8'h30, 28'h0}));
        reset = 1'b0;
        step();

        // Basic TX: dst (0,0), len 2, tag 5A from (1,0).
        exp_tx_q.push_back(32'h5A02_0100);
        exp_tx_q.push_back(32'h0000_000A);
        exp_tx_q.push_back(32'h0000_000B);
        tx_words.push_back(32'h0000_000A);
        tx_words.push_back(32'h0000_000B);
        send_tx(4'd0, 4'd0, 8'd2, 8'h5A);
        check("tx_ready_after_pkt", 64'(tx_ready), 64'd1);

        // Zero-length TX: header only, txd_ready never rises.
        exp_tx_q.push_back(32'h0100_0112);
        watch_txd = 1'b1;
        send_tx(4'd2, 4'd1, 8'd0, 8'h01);
        step();
        watch_txd = 1'b0;

        // RX with header backpressure: src (2,3), len 3, tag 11.
        exp_rxh_q.push_back(24'h11_03_32);
        exp_rxd_q.push_back({1'b0, 32'h1111_0001});
        exp_rxd_q.push_back({1'b0, 32'h1111_0002});
        exp_rxd_q.push_back({1'b1, 32'h1111_0003});
        rx_hdr_ready = 1'b0;
        fork
            begin
                send_rx_flit(32'h1103_3201);
                check("rx_hdr_latency", 64'(rx_hdr_valid), 64'd1);
                send_rx_flit(32'h1111_0001);
                send_rx_flit(32'h1111_0002);
                send_rx_flit(32'h1111_0003);
            end
            begin
                int b = 0;
                while (!rx_hdr_valid && b < 50) begin step(); b++; end
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    check("noc_i_ready_while_hdr_wait", 64'(noc_i_ready), 64'd0);
                    step();
                end
                rx_hdr_ready = 1'b1;
            end
        join
        wait_rx_idle();

        // Zero-length RX: header only, src (6,7), tag 20.
        exp_rxh_q.push_back(24'h20_00_76);
        send_rx_flit(32'h2000_7601);
        wait_rx_idle();

        // Misrouted: dst (2,0), len 2; both words swallowed, one rx_err.
        exp_err = 1;
        send_rx_flit(32'hEE02_5502);
        send_rx_flit(32'hCAFE_0001);
        send_rx_flit(32'hCAFE_0002);
        wait_rx_idle();
        step();
        check("rx_err_seen", 64'(exp_err), 64'd0);

        // Next correctly routed packet: src (3,4), len 1, tag 77.
        exp_rxh_q.push_back(24'h77_01_43);
        exp_rxd_q.push_back({1'b1, 32'hDEAD_BEEF});
        send_rx_flit(32'h7701_4301);
        send_rx_flit(32'hDEAD_BEEF);
        wait_rx_idle();

        // Max length with random ready and payload stalls: 256 flits in order.
        exp_tx_q.push_back(32'hC3FF_0123);
        for (int i = 0; i < 255; i++) begin
            exp_tx_q.push_back(32'hB000_0000 + 32'(i));
            tx_words.push_back(32'hB000_0000 + 32'(i));
        end
        rand_stall = 1'b1;
        send_tx(4'd3, 4'd2, 8'd255, 8'hC3);
        rand_stall = 1'b0;
        step();
        check("max_len_all_flits", 64'(exp_tx_q.size()), 64'd0);

        // Mid-packet reset: get TX and RX both into PAY, then reset.
        exp_tx_q.push_back(32'h4404_0111);
        exp_tx_q.push_back(32'h5000_0001);
        tx_valid = 1'b1; tx_dst_x = 4'd1; tx_dst_y = 4'd1; tx_len = 8'd4; tx_tag = 8'h44;
        step();
        tx_valid = 1'b0;
        step();
        txd_valid = 1'b1; txd_dat = 32'h5000_0001;
        step();
        txd_valid = 1'b0;
        exp_rxh_q.push_back(24'h55_04_22);
        exp_rxd_q.push_back({1'b0, 32'hAAAA_0001});
        send_rx_flit(32'h5504_2201);
        send_rx_flit(32'hAAAA_0001);
        check("both_in_pay", 64'({dbg_tx_state, dbg_rx_state}), 64'({2'(ST_PAY), 2'(ST_PAY)}));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_values", 64'({noc_e_valid, txd_ready, tx_ready, noc_i_ready, rx_hdr_valid,
              rxd_valid, rxd_last, rx_err, rx_src_x, rx_src_y, rx_len, rx_tag,
              dbg_tx_state, dbg_rx_state}), 64'({8'h30, 28'h0}));

        // Traffic after reset on both paths.
        exp_tx_q.push_back(32'h9901_0110);
        exp_tx_q.push_back(32'h1234_5678);
        tx_words.push_back(32'h1234_5678);
        send_tx(4'd0, 4'd1, 8'd1, 8'h99);
        exp_rxh_q.push_back(24'h66_01_00);
        exp_rxd_q.push_back({1'b1, 32'h0BAD_F00D});
        send_rx_flit(32'h6601_0001);
        send_rx_flit(32'h0BAD_F00D);
        wait_rx_idle();
        repeat (2) step();

        // ---------------- final report ----------------
        check("tx_q_drained", 64'(exp_tx_q.size()), 64'd0);
        check("rxh_q_drained", 64'(exp_rxh_q.size()), 64'd0);
        check("rxd_q_drained", 64'(exp_rxd_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
